// File: rtl/game_round_ctrl.sv
// Round sequencer for a timed game: start, countdown, play,
// pause and game-over, with a saturating completed-round count.
module game_round_ctrl #(
  parameter int unsigned COUNTDOWN_SECS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       tick_1hz,
  input  logic [7:0] time_left,
  output logic       timer_go,
  output logic       timer_restart,
  output logic [2:0] game_state,
  output logic [1:0] countdown,
  output logic       round_over,
  output logic [3:0] rounds_played
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RELOAD    = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_PAUSE     = 3'd4,
    S_OVER      = 3'd5
  } state_e;

  localparam logic [1:0] CD_INIT = 2'(COUNTDOWN_SECS);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       go_q;
  logic       restart_q;
  logic       over_q;
  logic [3:0] rounds_q;
  logic       enter_over;

  // Next state; one transition per cycle, so a consumed
  // button cannot act again in the destination state.
  always_comb begin
    state_d = state_q;
    cnt_d   = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (start_btn) state_d = S_RELOAD;
      end
      S_RELOAD: begin
        state_d = S_COUNTDOWN;
        cnt_d   = CD_INIT;
      end
      S_COUNTDOWN: begin
        cnt_d = cnt_q;
        if (tick_1hz) begin
          if (cnt_q <= 2'd1) begin
            state_d = S_PLAY;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_PLAY: begin
        if (time_left == 8'd0) state_d = S_OVER;
        else if (pause_btn)    state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (start_btn)      state_d = S_RELOAD;
        else if (pause_btn) state_d = S_PLAY;
      end
      S_OVER: begin
        if (start_btn) state_d = S_RELOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_over = (state_d == S_OVER) &&
                      (state_q != S_OVER);

  // State and outputs registered together so outputs
  // change on the same edge as the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      go_q      <= 1'b0;
      restart_q <= 1'b0;
      over_q    <= 1'b0;
      rounds_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_q      <= (state_d == S_PLAY);
      restart_q <= (state_d == S_RELOAD);
      over_q    <= enter_over;
      if (enter_over && rounds_q != 4'd15)
        rounds_q <= rounds_q + 4'd1;
    end
  end

  assign game_state    = state_q;
  assign countdown     = cnt_q;
  assign timer_go      = go_q;
  assign timer_restart = restart_q;
  assign round_over    = over_q;
  assign rounds_played = rounds_q;

endmodule
